// File: rtl/pll_lock_pkg.sv
// rtl/pll_lock_pkg.sv - shared state encoding and width helpers for the PLL lock manager
package pll_lock_pkg;

    typedef logic [2:0] chan_state_t;

    localparam chan_state_t ST_PRST  = 3'd0;
    localparam chan_state_t ST_WLOCK = 3'd1;
    localparam chan_state_t ST_STAB  = 3'd2;
    localparam chan_state_t ST_RUN   = 3'd3;
    localparam chan_state_t ST_FAIL  = 3'd4;

    // One timer serves all three phases, so it must hold the longest of them.
    function automatic int timer_w(input int rst_cycles, input int timeout, input int stable);
        int m;
        m = (timeout > stable) ? timeout : stable;
        if (rst_cycles > m) m = rst_cycles;
        return $clog2(m + 1);
    endfunction

    function automatic int retry_w(input int max_retries);
        return $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/pll_lock_mgr_if.sv
// rtl/pll_lock_mgr_if.sv - control/status bundle between the lock manager and its PLL channels
interface pll_lock_mgr_if #(
    parameter int NUM_PLLS = 2,
    parameter int CNT_W    = 8
);
    logic [NUM_PLLS-1:0]       pll_locked;
    logic [NUM_PLLS-1:0]       force_reset;
    logic                      clr_cnt;
    logic [NUM_PLLS-1:0]       pll_rst;
    logic [NUM_PLLS-1:0]       user_rst_n;
    logic [NUM_PLLS-1:0]       ready;
    logic                      all_ready;
    logic [NUM_PLLS-1:0]       fail;
    logic [NUM_PLLS*CNT_W-1:0] loss_cnt;

    modport master (
        input  pll_locked, force_reset, clr_cnt,
        output pll_rst, user_rst_n, ready, all_ready, fail, loss_cnt
    );

    modport slave (
        output pll_locked, force_reset, clr_cnt,
        input  pll_rst, user_rst_n, ready, all_ready, fail, loss_cnt
    );
endinterface

// File: rtl/pll_lock_chan.sv
// rtl/pll_lock_chan.sv - one PLL channel: lock synchroniser, supervisor FSM, retry and loss counters
module pll_lock_chan
    import pll_lock_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 3,
    parameter int CNT_W              = 8
) (
    input  logic             refclk_i,
    input  logic             rst_ni,
    input  logic             pll_locked_i,
    input  logic             force_reset_i,
    input  logic             clr_cnt_i,
    output logic             pll_rst_o,
    output logic             user_rst_n_o,
    output logic             ready_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] loss_cnt_o
);
    localparam int TW = timer_w(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);
    localparam int RW = retry_w(MAX_RETRIES);

    localparam logic [TW-1:0]    RST_END   = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0]    TO_END    = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]    STAB_END  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_LIM = RW'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             lk_meta_q, lk_s_q;
    chan_state_t      state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             pll_rst_q, user_rst_n_q;
    logic             loss_evt;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        loss_evt = 1'b0;
        if (force_reset_i) begin
            state_d = ST_PRST;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_PRST: begin
                    if (timer_q == RST_END) begin
                        state_d = ST_WLOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_WLOCK: begin
                    if (lk_s_q) begin
                        state_d = ST_STAB;
                        timer_d = '0;
                    end else if (timer_q == TO_END) begin
                        retry_d = retry_q + 1'b1;
                        timer_d = '0;
                        state_d = (retry_d == RETRY_LIM) ? ST_FAIL : ST_PRST;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_STAB: begin
                    // A dropout here is chatter, not a loss: restart the wait without penalty.
                    if (!lk_s_q) begin
                        state_d = ST_WLOCK;
                        timer_d = '0;
                    end else if (timer_q == STAB_END) begin
                        state_d = ST_RUN;
                        timer_d = '0;
                        retry_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lk_s_q) begin
                        state_d  = ST_PRST;
                        timer_d  = '0;
                        loss_evt = 1'b1;
                    end
                end
                ST_FAIL: ;
                default: begin
                    state_d = ST_PRST;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        loss_d = loss_q;
        if (clr_cnt_i) begin
            loss_d = '0;
        end else if (loss_evt && (loss_q != CNT_MAX)) begin
            loss_d = loss_q + 1'b1;
        end
    end

    // Resets are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge refclk_i) begin
        if (!rst_ni) begin
            lk_meta_q    <= 1'b0;
            lk_s_q       <= 1'b0;
            state_q      <= ST_PRST;
            timer_q      <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            pll_rst_q    <= 1'b1;
            user_rst_n_q <= 1'b0;
        end else begin
            lk_meta_q    <= pll_locked_i;
            lk_s_q       <= lk_meta_q;
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            pll_rst_q    <= (state_d == ST_PRST) || (state_d == ST_FAIL);
            user_rst_n_q <= (state_d == ST_RUN);
        end
    end

    assign pll_rst_o    = pll_rst_q;
    assign user_rst_n_o = user_rst_n_q;
    assign ready_o      = (state_q == ST_RUN);
    assign fail_o       = (state_q == ST_FAIL);
    assign loss_cnt_o   = loss_q;

endmodule

// File: rtl/pll_lock_mgr.sv
// rtl/pll_lock_mgr.sv - N-channel PLL supervisor: per-channel lock management and packed status
module pll_lock_mgr
    import pll_lock_pkg::*;
#(
    parameter int NUM_PLLS           = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 3,
    parameter int CNT_W              = 8
) (
    input  logic           refclk,
    input  logic           rst,
    pll_lock_mgr_if.master bus
);
    logic [NUM_PLLS-1:0]       pll_rst_v;
    logic [NUM_PLLS-1:0]       user_rst_n_v;
    logic [NUM_PLLS-1:0]       ready_v;
    logic [NUM_PLLS-1:0]       fail_v;
    logic [NUM_PLLS*CNT_W-1:0] loss_cnt_v;

    for (genvar i = 0; i < NUM_PLLS; i++) begin : g_chan
        pll_lock_chan #(
            .PLL_RST_CYCLES    (PLL_RST_CYCLES),
            .LOCK_TIMEOUT      (LOCK_TIMEOUT),
            .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
            .MAX_RETRIES       (MAX_RETRIES),
            .CNT_W             (CNT_W)
        ) u_chan (
            .refclk_i     (refclk),
            .rst_ni       (rst),
            .pll_locked_i (bus.pll_locked[i]),
            .force_reset_i(bus.force_reset[i]),
            .clr_cnt_i    (bus.clr_cnt),
            .pll_rst_o    (pll_rst_v[i]),
            .user_rst_n_o (user_rst_n_v[i]),
            .ready_o      (ready_v[i]),
            .fail_o       (fail_v[i]),
            .loss_cnt_o   (loss_cnt_v[i*CNT_W +: CNT_W])
        );
    end

    assign bus.pll_rst    = pll_rst_v;
    assign bus.user_rst_n = user_rst_n_v;
    assign bus.ready      = ready_v;
    assign bus.fail       = fail_v;
    assign bus.loss_cnt   = loss_cnt_v;
    assign bus.all_ready  = &ready_v;

endmodule

// File: tb/tb_pll_lock_mgr.sv
// tb/tb_pll_lock_mgr.sv - directed self-checking bench for pll_lock_mgr
module tb_pll_lock_mgr;
    logic refclk = 1'b0;
    logic rst_a, rst_b;
    int tests_run = 0;
    int tests_failed = 0;

    always #5 refclk = ~refclk;

    pll_lock_mgr_if #(.NUM_PLLS(2), .CNT_W(8)) bus_a ();
    pll_lock_mgr_if #(.NUM_PLLS(1), .CNT_W(8)) bus_b ();

    pll_lock_mgr #(
        .NUM_PLLS(2), .PLL_RST_CYCLES(16), .LOCK_TIMEOUT(65536),
        .LOCK_STABLE_CYCLES(1024), .MAX_RETRIES(3), .CNT_W(8)
    ) dut_a (.refclk(refclk), .rst(rst_a), .bus(bus_a));

    pll_lock_mgr #(
        .NUM_PLLS(1), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(100),
        .LOCK_STABLE_CYCLES(8), .MAX_RETRIES(3), .CNT_W(8)
    ) dut_b (.refclk(refclk), .rst(rst_b), .bus(bus_b));

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic test_reset();
        bus_a.pll_locked = 2'b11;
        rst_a = 1'b0; step(1); rst_a = 1'b1;
        tests_run++; if (bus_a.pll_rst !== 2'b11) begin tests_failed++; $display("FAIL reset_pll_rst: got %b exp 11", bus_a.pll_rst); end
        tests_run++; if (bus_a.user_rst_n !== 2'b00) begin tests_failed++; $display("FAIL reset_user_rst_n: got %b exp 00", bus_a.user_rst_n); end
        tests_run++; if (bus_a.ready !== 2'b00 || bus_a.all_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b/%b exp 00/0", bus_a.ready, bus_a.all_ready); end
        tests_run++; if (bus_a.fail !== 2'b00) begin tests_failed++; $display("FAIL reset_fail: got %b exp 00", bus_a.fail); end
        tests_run++; if (bus_a.loss_cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_loss: got %h exp 0000", bus_a.loss_cnt); end
    endtask

    task automatic test_nominal();
        rst_a = 1'b0; step(1); rst_a = 1'b1;
        step(15);
        tests_run++; if (bus_a.pll_rst !== 2'b11) begin tests_failed++; $display("FAIL nom_prst_15: got %b exp 11", bus_a.pll_rst); end
        step(1);
        tests_run++; if (bus_a.pll_rst !== 2'b00) begin tests_failed++; $display("FAIL nom_prst_16: got %b exp 00", bus_a.pll_rst); end
        step(1024);
        tests_run++; if (bus_a.ready !== 2'b00 || bus_a.user_rst_n !== 2'b00) begin tests_failed++; $display("FAIL nom_early_1040: got %b/%b exp 00/00", bus_a.ready, bus_a.user_rst_n); end
        step(1);
        tests_run++; if (bus_a.ready !== 2'b11 || bus_a.user_rst_n !== 2'b11 || bus_a.all_ready !== 1'b1) begin tests_failed++; $display("FAIL nom_ready_1041: got %b/%b/%b exp 11/11/1", bus_a.ready, bus_a.user_rst_n, bus_a.all_ready); end
        tests_run++; if (bus_a.loss_cnt !== 16'h0) begin tests_failed++; $display("FAIL nom_loss: got %h exp 0000", bus_a.loss_cnt); end
    endtask

    task automatic test_chatter();
        rst_a = 1'b0; step(1); rst_a = 1'b1;
        step(515);
        bus_a.pll_locked[0] = 1'b0;
        step(1);
        bus_a.pll_locked[0] = 1'b1;
        step(2);
        tests_run++; if (bus_a.pll_rst !== 2'b00 || bus_a.ready !== 2'b00) begin tests_failed++; $display("FAIL chat_wlock: got %b/%b exp 00/00", bus_a.pll_rst, bus_a.ready); end
        step(523);
        tests_run++; if (bus_a.ready !== 2'b10 || bus_a.all_ready !== 1'b0) begin tests_failed++; $display("FAIL chat_indep_1041: got %b/%b exp 10/0", bus_a.ready, bus_a.all_ready); end
        step(501);
        tests_run++; if (bus_a.ready !== 2'b10) begin tests_failed++; $display("FAIL chat_early_1542: got %b exp 10", bus_a.ready); end
        step(1);
        tests_run++; if (bus_a.ready !== 2'b11 || bus_a.all_ready !== 1'b1) begin tests_failed++; $display("FAIL chat_ready_1543: got %b/%b exp 11/1", bus_a.ready, bus_a.all_ready); end
        tests_run++; if (bus_a.loss_cnt !== 16'h0 || bus_a.fail !== 2'b00) begin tests_failed++; $display("FAIL chat_loss_fail: got %h/%b exp 0000/00", bus_a.loss_cnt, bus_a.fail); end
    endtask

    task automatic test_loss_run();
        bus_a.pll_locked[1] = 1'b0;
        step(2);
        tests_run++; if (bus_a.user_rst_n !== 2'b11 || bus_a.ready !== 2'b11) begin tests_failed++; $display("FAIL loss_early: got %b/%b exp 11/11", bus_a.user_rst_n, bus_a.ready); end
        step(1);
        tests_run++; if (bus_a.user_rst_n !== 2'b01 || bus_a.pll_rst !== 2'b10) begin tests_failed++; $display("FAIL loss_resets: got %b/%b exp 01/10", bus_a.user_rst_n, bus_a.pll_rst); end
        tests_run++; if (bus_a.ready !== 2'b01 || bus_a.all_ready !== 1'b0) begin tests_failed++; $display("FAIL loss_ready: got %b/%b exp 01/0", bus_a.ready, bus_a.all_ready); end
        tests_run++; if (bus_a.loss_cnt !== 16'h0100) begin tests_failed++; $display("FAIL loss_cnt1: got %h exp 0100", bus_a.loss_cnt); end
        step(2);
        bus_a.pll_locked[1] = 1'b1;
        step(1038);
        tests_run++; if (bus_a.ready !== 2'b01) begin tests_failed++; $display("FAIL loss_relock_early: got %b exp 01", bus_a.ready); end
        step(1);
        tests_run++; if (bus_a.ready !== 2'b11 || bus_a.loss_cnt !== 16'h0100) begin tests_failed++; $display("FAIL loss_relock: got %b/%h exp 11/0100", bus_a.ready, bus_a.loss_cnt); end
    endtask

    task automatic test_mid_reset();
        rst_a = 1'b0; step(1); rst_a = 1'b1;
        tests_run++; if (bus_a.pll_rst !== 2'b11 || bus_a.user_rst_n !== 2'b00) begin tests_failed++; $display("FAIL mid_resets: got %b/%b exp 11/00", bus_a.pll_rst, bus_a.user_rst_n); end
        tests_run++; if (bus_a.ready !== 2'b00 || bus_a.all_ready !== 1'b0 || bus_a.fail !== 2'b00) begin tests_failed++; $display("FAIL mid_status: got %b/%b/%b exp 00/0/00", bus_a.ready, bus_a.all_ready, bus_a.fail); end
        tests_run++; if (bus_a.loss_cnt !== 16'h0) begin tests_failed++; $display("FAIL mid_loss: got %h exp 0000", bus_a.loss_cnt); end
        step(16);
        tests_run++; if (bus_a.pll_rst !== 2'b00) begin tests_failed++; $display("FAIL mid_prst_end: got %b exp 00", bus_a.pll_rst); end
        step(1025);
        tests_run++; if (bus_a.ready !== 2'b11) begin tests_failed++; $display("FAIL mid_ready: got %b exp 11", bus_a.ready); end
    endtask

    task automatic test_clr_priority();
        bus_a.pll_locked[1] = 1'b0;
        step(2);
        bus_a.clr_cnt = 1'b1;
        step(1);
        bus_a.clr_cnt = 1'b0;
        tests_run++; if (bus_a.loss_cnt !== 16'h0) begin tests_failed++; $display("FAIL clr_vs_loss: got %h exp 0000", bus_a.loss_cnt); end
        tests_run++; if (bus_a.ready !== 2'b01 || bus_a.all_ready !== 1'b0 || bus_a.pll_rst !== 2'b10) begin tests_failed++; $display("FAIL clr_indep: got %b/%b/%b exp 01/0/10", bus_a.ready, bus_a.all_ready, bus_a.pll_rst); end
        bus_a.pll_locked[1] = 1'b1;
        step(5);
        tests_run++; if (bus_a.ready[0] !== 1'b1 || bus_a.user_rst_n[0] !== 1'b1) begin tests_failed++; $display("FAIL clr_ch0_hold: got %b/%b exp 1/1", bus_a.ready[0], bus_a.user_rst_n[0]); end
    endtask

    task automatic test_timeout_fail();
        int rises;
        int fail_at;
        logic prev;
        rises = 0; fail_at = -1;
        bus_b.pll_locked = 1'b0;
        rst_b = 1'b0; step(1); rst_b = 1'b1;
        prev = bus_b.pll_rst;
        tests_run++; if (bus_b.pll_rst !== 1'b1 || bus_b.fail !== 1'b0) begin tests_failed++; $display("FAIL to_reset: got %b/%b exp 1/0", bus_b.pll_rst, bus_b.fail); end
        for (int c = 1; c <= 400; c++) begin
            step(1);
            if (bus_b.pll_rst === 1'b1 && prev === 1'b0) rises++;
            if (bus_b.fail === 1'b1 && fail_at < 0) fail_at = c;
            prev = bus_b.pll_rst;
        end
        tests_run++; if (rises != 3) begin tests_failed++; $display("FAIL to_prst_pulses: got %0d exp 3", rises); end
        tests_run++; if (fail_at != 312) begin tests_failed++; $display("FAIL to_fail_cycle: got %0d exp 312", fail_at); end
        tests_run++; if (bus_b.pll_rst !== 1'b1 || bus_b.user_rst_n !== 1'b0 || bus_b.fail !== 1'b1) begin tests_failed++; $display("FAIL to_fail_hold: got %b/%b/%b exp 1/0/1", bus_b.pll_rst, bus_b.user_rst_n, bus_b.fail); end
        bus_b.pll_locked = 1'b1;
        bus_b.force_reset = 1'b1;
        step(1);
        bus_b.force_reset = 1'b0;
        tests_run++; if (bus_b.fail !== 1'b0 || bus_b.pll_rst !== 1'b1) begin tests_failed++; $display("FAIL force_exit: got %b/%b exp 0/1", bus_b.fail, bus_b.pll_rst); end
        step(12);
        tests_run++; if (bus_b.ready !== 1'b0) begin tests_failed++; $display("FAIL force_early: got %b exp 0", bus_b.ready); end
        step(1);
        tests_run++; if (bus_b.ready !== 1'b1 || bus_b.user_rst_n !== 1'b1 || bus_b.all_ready !== 1'b1) begin tests_failed++; $display("FAIL force_run: got %b/%b/%b exp 1/1/1", bus_b.ready, bus_b.user_rst_n, bus_b.all_ready); end
        tests_run++; if (bus_b.loss_cnt !== 8'd0) begin tests_failed++; $display("FAIL force_loss: got %0d exp 0", bus_b.loss_cnt); end
    endtask

    task automatic test_saturate();
        int n;
        for (int it = 0; it < 300; it++) begin
            bus_b.pll_locked = 1'b0;
            step(5);
            bus_b.pll_locked = 1'b1;
            if (it == 0) begin
                step(10);
                tests_run++; if (bus_b.ready !== 1'b0) begin tests_failed++; $display("FAIL sat_relock_early: got %b exp 0", bus_b.ready); end
                step(1);
                tests_run++; if (bus_b.ready !== 1'b1 || bus_b.loss_cnt !== 8'd1) begin tests_failed++; $display("FAIL sat_relock: got %b/%0d exp 1/1", bus_b.ready, bus_b.loss_cnt); end
            end else begin
                n = 0;
                while (bus_b.ready !== 1'b1 && n < 100) begin step(1); n++; end
                tests_run++; if (n >= 100) begin tests_failed++; $display("FAIL sat_wait_ready: iter %0d got timeout exp ready", it); end
            end
            if (it == 253) begin
                tests_run++; if (bus_b.loss_cnt !== 8'd254) begin tests_failed++; $display("FAIL sat_cnt254: got %0d exp 254", bus_b.loss_cnt); end
            end
        end
        tests_run++; if (bus_b.loss_cnt !== 8'd255) begin tests_failed++; $display("FAIL sat_cnt255: got %0d exp 255", bus_b.loss_cnt); end
        bus_b.clr_cnt = 1'b1;
        step(1);
        bus_b.clr_cnt = 1'b0;
        tests_run++; if (bus_b.loss_cnt !== 8'd0 || bus_b.ready !== 1'b1) begin tests_failed++; $display("FAIL sat_clr: got %0d/%b exp 0/1", bus_b.loss_cnt, bus_b.ready); end
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.pll_locked  = 2'b11;
        bus_a.force_reset = 2'b00;
        bus_a.clr_cnt     = 1'b0;
        bus_b.pll_locked  = 1'b0;
        bus_b.force_reset = 1'b0;
        bus_b.clr_cnt     = 1'b0;
        step(2);
        test_reset();
        test_nominal();
        test_chatter();
        test_loss_run();
        test_mid_reset();
        test_clr_priority();
        test_timeout_fail();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
